// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared defaults, FSM states and requester index type
// for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int ADDR_W_DEF     = 4;
    localparam int RD_TIMEOUT_DEF = 15;
    localparam int TMO_CNT_W      = $clog2(RD_TIMEOUT_DEF + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } arb_state_e;

    typedef logic req_id_t;

    function automatic int tmo_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; the requester
// that did not win last time takes a tie.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  req_id_t    i_last,
    output logic [1:0] o_grant,
    output req_id_t    o_winner
);

    always_comb begin
        o_winner = 1'b0;
        unique case (1'b1)
            (i_valid == 2'b11): o_winner = ~i_last;
            (i_valid == 2'b10): o_winner = 1'b1;
            default:            o_winner = 1'b0;
        endcase
        o_grant = '0;
        if (|i_valid) begin
            o_grant = o_winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one single-port memory by two
// requesters. Optional read abort: define MEM_ARB_RD_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int ADDR_WIDTH = ADDR_W_DEF
`ifdef MEM_ARB_RD_TIMEOUT_EN
    ,
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
`endif
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    mem_write_en,
    output logic                    mem_read_en,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_data_in,
    input  logic [DATA_WIDTH-1:0]   mem_data_out,
    input  logic                    mem_valid_out
);

    arb_state_e            r_state;
    arb_state_e            w_next;
    logic [1:0]            w_grant;
    req_id_t               w_winner;
    req_id_t               r_last;
    req_id_t               r_owner;
    logic                  w_accept;
    logic                  w_rd_done;
    logic                  w_tmo;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

`ifdef MEM_ARB_RD_TIMEOUT_EN
    localparam int CNT_W = tmo_cnt_w(RD_TIMEOUT);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
`endif

    rr_arb2 u_rr (
        .i_valid  (req_valid),
        .i_last   (r_last),
        .o_grant  (w_grant),
        .o_winner (w_winner)
    );

    assign w_sel_addr  = w_winner ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                  : req_addr[ADDR_WIDTH-1:0];
    assign w_sel_wdata = w_winner ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                  : req_wdata[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        req_ready    = '0;
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        w_accept     = 1'b0;
        w_rd_done    = 1'b0;
        w_tmo        = 1'b0;
        unique case (r_state)
            IDLE: begin
                // keep ready low while reset is held, even with valid high
                req_ready = w_grant & {2{reset_n}};
                if (|req_valid) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                end
            end
            ISSUE: begin
                mem_write_en = r_we;
                mem_read_en  = ~r_we;
                w_next       = r_we ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (mem_valid_out) begin
                    w_rd_done = 1'b1;
                    w_next    = IDLE;
                end
`ifdef MEM_ARB_RD_TIMEOUT_EN
                else if (r_cnt == CNT_W'(RD_TIMEOUT)) begin
                    w_tmo  = 1'b1;
                    w_next = IDLE;
                end
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_rsp_valid <= '0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_we    <= req_we[w_winner];
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_owner <= w_winner;
                r_last  <= w_winner;
            end
            if (w_rd_done || w_tmo) begin
                r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
                r_rdata     <= w_tmo ? '0 : mem_data_out;
            end
        end
    end

`ifdef MEM_ARB_RD_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_tmo;
            if (r_state == ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == WAIT_RD && !mem_valid_out) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign mem_address = r_addr;
    assign mem_data_in = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against
// a behavioural memory and a reference model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW = 4;
    localparam int DW = 32;

    logic            clk;
    logic            reset_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            mem_write_en;
    logic            mem_read_en;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_data_in;
    logic [DW-1:0]   mem_data_out;
    logic            mem_valid_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem_arr [16];
    logic [DW-1:0] ref_mem [16];
    int lat        = 0;
    bit spur       = 1'b0;
    bit release_rd = 1'b0;

    mem_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .mem_write_en  (mem_write_en),
        .mem_read_en   (mem_read_en),
        .mem_address   (mem_address),
        .mem_data_in   (mem_data_in),
        .mem_data_out  (mem_data_out),
        .mem_valid_out (mem_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    task automatic wait_rsp(input int limit, output int n);
        n = 0;
        while (rsp_valid == 2'b00 && n < limit) begin
            tick();
            #1;
            n++;
        end
    endtask

    // behavioural memory: latency lat cycles after read_en, plus
    // injectable spurious and forced valid_out pulses
    initial begin
        bit            pend;
        int            pcnt;
        logic [AW-1:0] paddr;
        pend = 1'b0;
        pcnt = 0;
        paddr = '0;
        mem_valid_out = 1'b0;
        mem_data_out = '0;
        for (int i = 0; i < 16; i++) mem_arr[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_valid_out = 1'b0;
            if (!reset_n) pend = 1'b0;
            if (spur) begin
                mem_valid_out = 1'b1;
                mem_data_out  = 32'hBAD0_0BAD;
            end
            if (pend) begin
                if (pcnt == 0 || release_rd) begin
                    mem_valid_out = 1'b1;
                    mem_data_out  = mem_arr[paddr];
                    pend = 1'b0;
                end else begin
                    pcnt--;
                end
            end
            if (mem_write_en) mem_arr[mem_address] = mem_data_in;
            if (mem_read_en) begin
                pend  = 1'b1;
                pcnt  = lat;
                paddr = mem_address;
            end
        end
    end

    initial begin
        int            n;
        int            g;
        int            both;
        logic [1:0]    v;
        logic [1:0]    we;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [AW-1:0] ea;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] ed;
        logic          w;
        logic          m_last;
        logic          exp_we;

        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        // reset with both requesters valid: every output must be 0
        reset_n = 1'b0;
        drive(2'b11, 2'b00, 4'h0, 4'h0, '0, '0);
        tick();
        tick();
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_wr_en", 32'(mem_write_en), 32'd0);
        chk("rst_rd_en", 32'(mem_read_en), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_wdata", mem_data_in, 32'd0);

        // REQ0 write 0x3 <- DEADBEEF
        reset_n = 1'b1;
        drive(2'b01, 2'b01, 4'h3, 4'h0, 32'hDEAD_BEEF, '0);
        #1;
        chk("t1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t1_wr_en", 32'(mem_write_en), 32'd1);
        chk("t1_rd_en", 32'(mem_read_en), 32'd0);
        chk("t1_addr", 32'(mem_address), 32'h3);
        chk("t1_wdata", mem_data_in, 32'hDEAD_BEEF);
        ref_mem[3] = 32'hDEAD_BEEF;
        tick();
        #1;
        chk("t1_wr_drop", 32'(mem_write_en), 32'd0);
        chk("t1_addr_hold", 32'(mem_address), 32'h3);

        // REQ1 read 0x3, memory answers one cycle after read_en
        lat = 0;
        drive(2'b10, 2'b00, 4'h0, 4'h3, '0, '0);
        #1;
        chk("t2_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t2_rd_en", 32'(mem_read_en), 32'd1);
        chk("t2_addr", 32'(mem_address), 32'h3);
        wait_rsp(20, n);
        chk("t2_rsp_lat", 32'(n), 32'd2);
        chk("t2_rsp_valid", 32'(rsp_valid), 32'd2);
        chk("t2_rdata", rsp_rdata, ref_mem[3]);
        chk("t2_err", 32'(rsp_err), 32'd0);
        tick();
        #1;
        chk("t2_pulse_len", 32'(rsp_valid), 32'd0);

        // both continuously valid: strict alternation starting at REQ0
        drive(2'b11, 2'b11, 4'h0, 4'h1, 32'h1111_0000, 32'h2222_0001);
        g = 0;
        n = 0;
        both = 0;
        while (g < 6 && n < 40) begin
            #1;
            if (mem_write_en && mem_read_en) both++;
            if (req_ready != 2'b00) begin
                chk("fair_grant", 32'(req_ready),
                    (g % 2 != 0) ? 32'd2 : 32'd1);
                if (req_ready[1]) ref_mem[1] = 32'h2222_0001;
                else              ref_mem[0] = 32'h1111_0000;
                g++;
            end
            tick();
            n++;
        end
        req_valid = 2'b00;
        chk("fair_count", 32'(g), 32'd6);
        chk("fair_one_strobe", 32'(both), 32'd0);
        tick();
        #1;

        // REQ0 read outstanding, REQ1 waiting, spurious pulse in ISSUE
        lat = 2;
        drive(2'b01, 2'b00, 4'h3, 4'h5, '0, 32'h5555_AAAA);
        #1;
        chk("t4_ready", 32'(req_ready), 32'd1);
        spur = 1'b1;
        tick();
        drive(2'b10, 2'b10, 4'h3, 4'h5, '0, 32'h5555_AAAA);
        #1;
        spur = 1'b0;
        chk("t4_rd_en", 32'(mem_read_en), 32'd1);
        chk("t4_iss_ready", 32'(req_ready), 32'd0);
        tick();
        #1;
        n = 0;
        while (rsp_valid == 2'b00 && n < 20) begin
            chk("t4_wait_ready", 32'(req_ready), 32'd0);
            tick();
            #1;
            n++;
        end
        chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t4_rdata", rsp_rdata, ref_mem[3]);
        chk("t4_err", 32'(rsp_err), 32'd0);
        chk("t4_ready_rsp", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        #1;
        chk("t4_wr_en", 32'(mem_write_en), 32'd1);
        chk("t4_wr_addr", 32'(mem_address), 32'h5);
        ref_mem[5] = 32'h5555_AAAA;
        tick();
        #1;

        // spurious pulse while IDLE must not disturb rsp_rdata
        spur = 1'b1;
        tick();
        #1;
        spur = 1'b0;
        tick();
        #1;
        chk("idle_spur_valid", 32'(rsp_valid), 32'd0);
        chk("idle_spur_rdata", rsp_rdata, 32'hDEAD_BEEF);

        // memory never answers a read of 0x5
        lat = 10000;
        drive(2'b01, 2'b00, 4'h5, 4'h6, '0, 32'h6666_0006);
        #1;
        chk("t5_ready", 32'(req_ready), 32'd1);
        tick();
        drive(2'b10, 2'b10, 4'h5, 4'h6, '0, 32'h6666_0006);
        #1;
        chk("t5_rd_en", 32'(mem_read_en), 32'd1);
`ifdef MEM_ARB_RD_TIMEOUT_EN
        wait_rsp(40, n);
        chk("tmo_lat", 32'(n), 32'd17);
        chk("tmo_valid", 32'(rsp_valid), 32'd1);
        chk("tmo_err", 32'(rsp_err), 32'd1);
        chk("tmo_rdata", rsp_rdata, 32'd0);
        chk("tmo_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        #1;
        chk("tmo_wr_en", 32'(mem_write_en), 32'd1);
        ref_mem[6] = 32'h6666_0006;
        release_rd = 1'b1;
        tick();
        #1;
        release_rd = 1'b0;
        chk("tmo_late_valid", 32'(rsp_valid), 32'd0);
        tick();
        #1;
        chk("tmo_late_valid2", 32'(rsp_valid), 32'd0);
        chk("tmo_err_clear", 32'(rsp_err), 32'd0);
`else
        for (int i = 0; i < 30; i++) begin
            tick();
            #1;
            chk("hang", 32'({req_ready, rsp_valid}), 32'd0);
        end
        release_rd = 1'b1;
        tick();
        #1;
        release_rd = 1'b0;
        wait_rsp(5, n);
        chk("hang_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hang_rdata", rsp_rdata, ref_mem[5]);
        chk("hang_err", 32'(rsp_err), 32'd0);
        chk("hang_ready", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        #1;
        chk("hang_wr_en", 32'(mem_write_en), 32'd1);
        ref_mem[6] = 32'h6666_0006;
        tick();
        #1;
`endif

        // reset pulsed while a read is outstanding
        lat = 10000;
        drive(2'b01, 2'b00, 4'h0, 4'h7, '0, 32'h7777_0007);
        #1;
        chk("t6_ready", 32'(req_ready), 32'd1);
        tick();
        drive(2'b10, 2'b10, 4'h0, 4'h7, '0, 32'h7777_0007);
        tick();
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("mid_rst_err", 32'(rsp_err), 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_strobes", 32'({mem_write_en, mem_read_en}), 32'd0);
        chk("mid_rst_addr", 32'(mem_address), 32'd0);
        chk("mid_rst_wdata", mem_data_in, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        drive(2'b11, 2'b11, 4'h8, 4'h7, 32'h8888_0008, 32'h7777_0007);
        #1;
        chk("rst_tie", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("rst_tie_addr", 32'(mem_address), 32'h8);
        ref_mem[8] = 32'h8888_0008;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        m_last = 1'b0;

        // randomized traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            tick();
            v   = 2'($urandom_range(1, 3));
            we  = 2'($urandom_range(0, 3));
            a0  = 4'($urandom_range(0, 15));
            a1  = 4'($urandom_range(0, 15));
            d0  = $urandom;
            d1  = $urandom;
            lat = $urandom_range(0, 3);
            drive(v, we, a0, a1, d0, d1);
            w = (v == 2'b11) ? ~m_last : v[1];
            #1;
            chk("rnd_ready", 32'(req_ready), w ? 32'd2 : 32'd1);
            tick();
            req_valid = 2'b00;
            #1;
            m_last = w;
            exp_we = w ? we[1] : we[0];
            ea     = w ? a1 : a0;
            ed     = w ? d1 : d0;
            chk("rnd_wr_en", 32'(mem_write_en), 32'(exp_we));
            chk("rnd_rd_en", 32'(mem_read_en), 32'(!exp_we));
            chk("rnd_addr", 32'(mem_address), 32'(ea));
            if (exp_we) begin
                chk("rnd_wdata", mem_data_in, ed);
                ref_mem[ea] = ed;
            end else begin
                wait_rsp(20, n);
                chk("rnd_rsp_valid", 32'(rsp_valid), w ? 32'd2 : 32'd1);
                chk("rnd_rdata", rsp_rdata, ref_mem[ea]);
                chk("rnd_err", 32'(rsp_err), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
